// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_queue
//  Purpose  : Instruction-fetch front end. Issues pipelined, in-order fetch
//             requests to instruction memory (up to DEPTH outstanding),
//             buffers returned words with their PCs in a DEPTH-entry FIFO and
//             presents them to decode over a valid/ready handshake. A
//             redirect flushes the FIFO and marks outstanding requests as
//             stale so their responses are dropped. Misaligned fetch PCs are
//             flagged per entry for the AdEL exception.
//  Ports    :
//    clk          in   clock, rising edge
//    rst          in   synchronous active-high reset
//    im_req       out  fetch request (memory accepts every asserted cycle)
//    im_addr      out  word-aligned fetch address
//    im_rvalid    in   response valid (in order, one per request)
//    im_rdata     in   response instruction word
//    redirect     in   flush and restart fetch at redirect_pc
//    redirect_pc  in   new fetch address (may be misaligned)
//    out_valid    out  head entry valid
//    out_ready    in   decode accepts the head entry
//    out_ins      out  head instruction word
//    out_pc       out  head PC
//    out_adel     out  head PC was misaligned
//  Revision : 1.0  initial release
// ============================================================================
module ifetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INS_W    = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_rvalid,
    input  logic [INS_W-1:0]  im_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INS_W-1:0]  out_ins,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_adel
);

    localparam int PW = $clog2(DEPTH);   // pointer width
    localparam int CW = PW + 1;          // counter width, holds 0..DEPTH
    localparam int SW = CW + 2;          // credit sum width, no overflow

    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);
    localparam logic [SW-1:0]     c_CREDITS = SW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q,  resp_pc_d;
    logic [CW-1:0]     count_q,    count_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     discard_q,  discard_d;
    logic [PW-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q,   wr_ptr_d;

    // FIFO storage is intentionally left unreset; count gates visibility.
    logic [INS_W-1:0]  ins_mem_q  [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic              adel_mem_q [DEPTH];

    logic [SW-1:0]     w_credit_sum;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;

    // Every outstanding request (live or stale) and every buffered entry
    // holds one credit, so a returning response always has a free slot.
    assign w_credit_sum = SW'(count_q) + SW'(inflight_q) + SW'(discard_q);

    assign im_req  = !rst && !redirect && (w_credit_sum < c_CREDITS);
    assign im_addr = {fetch_pc_q[ADDR_W-1:2], 2'b00};

    assign out_valid = !rst && (count_q != '0);
    assign out_ins   = out_valid ? ins_mem_q[rd_ptr_q]  : '0;
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]   : '0;
    assign out_adel  = out_valid ? adel_mem_q[rd_ptr_q] : 1'b0;

    // A response either retires one stale request or lands in the FIFO.
    assign w_drop = im_rvalid && (discard_q != '0);
    assign w_push = !rst && !redirect && im_rvalid && (discard_q == '0);
    assign w_pop  = !redirect && out_valid && out_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (redirect) begin
            // Everything outstanding becomes stale. A response arriving now
            // belongs to either the stale or the live pool (pre-redirect
            // view), and in both cases it retires one of the summed credits.
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            discard_d  = discard_q + inflight_q - CW'(im_rvalid);
            inflight_d = '0;
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
        end else begin
            if (im_req) begin
                fetch_pc_d = fetch_pc_q + c_PC_STEP;
            end
            inflight_d = inflight_q + CW'(im_req) - CW'(w_push);
            if (w_drop) begin
                discard_d = discard_q - CW'(1);
            end
            count_d = count_q + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
                wr_ptr_d  = wr_ptr_q + PW'(1);
                resp_pc_d = resp_pc_q + c_PC_STEP;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // The entry keeps the PC as fetched (low bits included) for AdEL.
    always_ff @(posedge clk) begin
        if (w_push) begin
            ins_mem_q[wr_ptr_q]  <= im_rdata;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
            adel_mem_q[wr_ptr_q] <= (resp_pc_q[1:0] != 2'b00);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch_queue
//  Purpose  : Directed self-checking bench for ifetch_queue with an in-order
//             fixed-latency instruction memory model. Memory returns
//             (address ^ 32'hDEAD_0000) for each aligned address.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifetch_queue;

    logic        clk;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        out_adel;

    int checks;
    int errors;
    int cyc;
    int lat;
    int nreq;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } req_t;

    req_t memq[$];

    ifetch_queue #(
        .ADDR_W   (32),
        .INS_W    (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_rvalid   (im_rvalid),
        .im_rdata    (im_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ins     (out_ins),
        .out_pc      (out_pc),
        .out_adel    (out_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: present the due memory response, capture any request,
    // then advance to 1 time unit after the rising edge.
    task automatic tick();
        if (rst) begin
            memq.delete();
            im_rvalid = 1'b0;
            im_rdata  = '0;
        end else if (memq.size() > 0 && memq[0].due <= cyc) begin
            im_rvalid = 1'b1;
            im_rdata  = memq[0].addr ^ 32'hDEAD_0000;
            void'(memq.pop_front());
        end else begin
            im_rvalid = 1'b0;
            im_rdata  = '0;
        end
        #1;
        if (im_req) begin
            memq.push_back('{cyc + lat, im_addr});
            nreq++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        lat         = 1;
        nreq        = 0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b1;
        im_rvalid   = 1'b0;
        im_rdata    = '0;

        // ---------------- Reset state and 1-cycle latency streaming ------
        tick();
        tick();
        chk("rst_im_req",    {31'b0, im_req},    32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc",    out_pc,             32'd0);
        chk("rst_out_ins",   out_ins,            32'd0);
        chk("rst_out_adel",  {31'b0, out_adel},  32'd0);
        rst = 1'b0;
        #1;
        chk("run_req0",  {31'b0, im_req}, 32'd1);
        chk("run_addr0", im_addr, 32'h0000_3000);
        tick();
        chk("run_valid_e1", {31'b0, out_valid}, 32'd0);
        chk("run_addr1",    im_addr, 32'h0000_3004);
        tick();
        chk("run_valid_e2", {31'b0, out_valid}, 32'd1);
        chk("run_pc_e2",    out_pc,  32'h0000_3000);
        chk("run_ins_e2",   out_ins, 32'hDEAD_3000);
        chk("run_adel_e2",  {31'b0, out_adel}, 32'd0);
        tick();
        chk("run_pc_e3", out_pc, 32'h0000_3004);
        tick();
        chk("run_pc_e4", out_pc, 32'h0000_3008);

        // ---------------- Backpressure: FIFO fills to DEPTH -------------
        out_ready = 1'b0;
        do_reset();
        nreq = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("bp_nreq",  nreq, 32'd4);
        chk("bp_req",   {31'b0, im_req}, 32'd0);
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_pc0",   out_pc, 32'h0000_3000);
        out_ready = 1'b1;
        tick();
        chk("bp_pc1", out_pc, 32'h0000_3004);
        tick();
        chk("bp_pc2", out_pc, 32'h0000_3008);
        tick();
        chk("bp_pc3", out_pc, 32'h0000_300C);
        tick();
        chk("bp_pc4", out_pc, 32'h0000_3010);

        // ---------------- Redirect with 3 stale requests, latency 3 ------
        lat = 3;
        do_reset();
        tick();
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_4000;
        #1;
        chk("rd3_req_blocked", {31'b0, im_req}, 32'd0);
        tick();
        redirect = 1'b0;
        chk("rd3_valid_e4", {31'b0, out_valid}, 32'd0);
        chk("rd3_addr",     im_addr, 32'h0000_4000);
        tick();
        chk("rd3_valid_e5", {31'b0, out_valid}, 32'd0);
        tick();
        chk("rd3_valid_e6", {31'b0, out_valid}, 32'd0);
        tick();
        chk("rd3_valid_e7", {31'b0, out_valid}, 32'd0);
        tick();
        chk("rd3_valid_e8", {31'b0, out_valid}, 32'd1);
        chk("rd3_pc",       out_pc,  32'h0000_4000);
        chk("rd3_ins",      out_ins, 32'hDEAD_4000);

        // ---------------- Redirect with response + pop, then again -------
        lat = 2;
        do_reset();
        tick();
        tick();
        tick();
        chk("rr_pre_valid", {31'b0, out_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_5000;
        tick();
        chk("rr_valid_e4", {31'b0, out_valid}, 32'd0);
        redirect_pc = 32'h0000_6000;
        tick();
        redirect = 1'b0;
        chk("rr_valid_e5", {31'b0, out_valid}, 32'd0);
        #1;
        chk("rr_req",  {31'b0, im_req}, 32'd1);
        chk("rr_addr", im_addr, 32'h0000_6000);
        tick();
        tick();
        chk("rr_valid_e7", {31'b0, out_valid}, 32'd0);
        tick();
        chk("rr_valid_e8", {31'b0, out_valid}, 32'd1);
        chk("rr_pc",       out_pc,  32'h0000_6000);
        chk("rr_ins",      out_ins, 32'hDEAD_6000);

        // ---------------- Misaligned redirect ----------------------------
        lat = 1;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_4002;
        tick();
        redirect = 1'b0;
        #1;
        chk("mis_addr0", im_addr, 32'h0000_4000);
        tick();
        chk("mis_addr1", im_addr, 32'h0000_4004);
        tick();
        chk("mis_pc0",   out_pc, 32'h0000_4002);
        chk("mis_adel0", {31'b0, out_adel}, 32'd1);
        chk("mis_ins0",  out_ins, 32'hDEAD_4000);
        tick();
        chk("mis_pc1",   out_pc, 32'h0000_4006);
        chk("mis_adel1", {31'b0, out_adel}, 32'd1);

        // ---------------- Reset with the FIFO full -----------------------
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        chk("full_valid", {31'b0, out_valid}, 32'd1);
        chk("full_req",   {31'b0, im_req},    32'd0);
        rst = 1'b1;
        tick();
        chk("frst_valid", {31'b0, out_valid}, 32'd0);
        chk("frst_req",   {31'b0, im_req},    32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("frst_req_after", {31'b0, im_req}, 32'd1);
        chk("frst_addr",      im_addr, 32'h0000_3000);
        tick();
        tick();
        chk("frst_pc",   out_pc,  32'h0000_3000);
        chk("frst_ins",  out_ins, 32'hDEAD_3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
